// File: rtl/regfile_sb.sv
// Register file with two write ports, optional write-to-read bypass and a
// per-register load scoreboard used by the decode-stage stall logic.
// Register ZERO_REG always reads as zero, ignores writes and is never busy.
module regfile_sb #(
  parameter int unsigned N        = 64,
  parameter int unsigned NREG     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned ZERO_REG = 31,
  parameter int unsigned BYPASS   = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  // read ports
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [N-1:0]  rd1,
  output logic [N-1:0]  rd2,
  // ALU writeback port
  input  logic          we3,
  input  logic [AW-1:0] wa3,
  input  logic [N-1:0]  wd3,
  // load writeback port
  input  logic          we4,
  input  logic [AW-1:0] wa4,
  input  logic [N-1:0]  wd4,
  // load issue and scoreboard status
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_wa,
  output logic          busy1,
  output logic          busy2,
  output logic [AW:0]   pending
);

  // Reject address widths that cannot reach every register.
  if ((2 ** AW) < NREG) begin : g_bad_aw
    $error("regfile_sb: AW too small for NREG");
  end

  logic [N-1:0]    regs_q [NREG];
  logic [N-1:0]    regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [AW:0]     pending_q;
  logic [AW:0]     pending_d;

  // Addresses that name a real, writable register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < NREG) && (32'(a) != ZERO_REG);
  endfunction

  logic w3_ok;
  logic w4_ok;
  logic iss_ok;
  logic ra1_ok;
  logic ra2_ok;
  logic set_eff;
  logic clr_eff;

  // Qualify every address once so the rest of the logic can trust it.
  always_comb begin
    w3_ok  = we3 && addr_ok(wa3);
    w4_ok  = we4 && addr_ok(wa4);
    iss_ok = iss_valid && addr_ok(iss_wa);
    ra1_ok = addr_ok(ra1);
    ra2_ok = addr_ok(ra2);
  end

  // Register write next-state; port 4 is applied last so it wins a tie.
  always_comb begin
    regs_d = regs_q;
    if (w3_ok) begin
      regs_d[wa3] = wd3;
    end
    if (w4_ok) begin
      regs_d[wa4] = wd4;
    end
  end

  // Scoreboard next-state: load writeback clears, issue sets, set wins a tie.
  always_comb begin
    busy_d = busy_q;
    if (w4_ok) begin
      busy_d[wa4] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[iss_wa] = 1'b1;
    end
  end

  // Pending counter tracks only transitions that change a busy bit.
  always_comb begin
    set_eff   = iss_ok && !busy_q[iss_wa];
    clr_eff   = w4_ok && busy_q[wa4] && !(iss_ok && (iss_wa == wa4));
    pending_d = pending_q + (AW + 1)'(set_eff) - (AW + 1)'(clr_eff);
  end

  // Register storage; reset loads each register with its own index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= (i == int'(ZERO_REG)) ? '0 : N'(i);
      end
    end else begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Scoreboard bits and outstanding-load count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

  // Read port 1: zero register and out-of-range read as 0, then bypass.
  always_comb begin
    rd1   = '0;
    busy1 = 1'b0;
    if (ra1_ok) begin
      rd1   = regs_q[ra1];
      busy1 = busy_q[ra1];
      if (BYPASS != 0) begin
        if (w4_ok && (wa4 == ra1)) begin
          rd1   = wd4;
          busy1 = 1'b0;
        end else if (w3_ok && (wa3 == ra1)) begin
          rd1 = wd3;
        end
      end
    end
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    rd2   = '0;
    busy2 = 1'b0;
    if (ra2_ok) begin
      rd2   = regs_q[ra2];
      busy2 = busy_q[ra2];
      if (BYPASS != 0) begin
        if (w4_ok && (wa4 == ra2)) begin
          rd2   = wd4;
          busy2 = 1'b0;
        end else if (w3_ok && (wa3 == ra2)) begin
          rd2 = wd3;
        end
      end
    end
  end

  assign pending = pending_q;

  // The counter must always equal the number of busy bits.
  a_pending_matches : assert property (
    @(posedge clk) disable iff (!reset_n) 32'(pending_q) == 32'($countones(busy_q))
  );

  // The hardwired-zero register can never be marked busy.
  if (ZERO_REG < NREG) begin : g_zero_chk
    a_zero_not_busy : assert property (
      @(posedge clk) disable iff (!reset_n) !busy_q[ZERO_REG]
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one instance with bypass, one without, sharing all
// inputs, checked against a behavioural array model of registers and busy bits.
module tb_regfile_sb;
  localparam int N    = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int ZR   = 31;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [AW-1:0] ra1, ra2, wa3, wa4, iss_wa;
  logic [N-1:0]  wd3, wd4;
  logic          we3, we4, iss_valid;

  logic [N-1:0]  rd1_b, rd2_b, rd1_n, rd2_n;
  logic          busy1_b, busy2_b, busy1_n, busy2_n;
  logic [AW:0]   pending_b, pending_n;

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0] mregs [NREG];
  bit           mbusy [NREG];

  always #5 clk = ~clk;

  regfile_sb #(.N(N), .NREG(NREG), .AW(AW), .ZERO_REG(ZR), .BYPASS(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
    .iss_valid(iss_valid), .iss_wa(iss_wa), .busy1(busy1_b), .busy2(busy2_b),
    .pending(pending_b)
  );

  regfile_sb #(.N(N), .NREG(NREG), .AW(AW), .ZERO_REG(ZR), .BYPASS(0)) dut_n (
    .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
    .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
    .iss_valid(iss_valid), .iss_wa(iss_wa), .busy1(busy1_n), .busy2(busy2_n),
    .pending(pending_n)
  );

  function automatic bit ok(input logic [AW-1:0] a);
    return (int'(a) < NREG) && (int'(a) != ZR);
  endfunction

  function automatic logic [N-1:0] exp_rd(input logic [AW-1:0] ra, input bit byp);
    if (!ok(ra)) return '0;
    if (byp && we4 && wa4 == ra) return wd4;
    if (byp && we3 && wa3 == ra) return wd3;
    return mregs[ra];
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] ra, input bit byp);
    if (!ok(ra)) return 1'b0;
    if (byp && we4 && wa4 == ra) return 1'b0;
    return mbusy[ra];
  endfunction

  function automatic int exp_pending();
    int c = 0;
    for (int i = 0; i < NREG; i++) c += int'(mbusy[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      mregs[i] = (i == ZR) ? '0 : N'(i);
      mbusy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    we3 = 1'b0; we4 = 1'b0; iss_valid = 1'b0;
  endtask

  // Advance one clock, applying the specified write and scoreboard rules.
  task automatic tick();
    logic [N-1:0] nregs [NREG];
    bit           nbusy [NREG];
    nregs = mregs;
    nbusy = mbusy;
    if (we3 && ok(wa3)) nregs[wa3] = wd3;
    if (we4 && ok(wa4)) nregs[wa4] = wd4;
    if (we4 && ok(wa4)) nbusy[wa4] = 1'b0;
    if (iss_valid && ok(iss_wa)) nbusy[iss_wa] = 1'b1;
    @(posedge clk);
    #1;
    mregs = nregs;
    mbusy = nbusy;
  endtask

  task automatic test_reset();
    idle();
    ra1 = '0; ra2 = '0; wa3 = '0; wa4 = '0; iss_wa = '0; wd3 = '0; wd4 = '0;
    #1 reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < 31; i++) begin
      ra1 = AW'(i);
      ra2 = AW'(i + 1);
      #1;
      n_tests++;
      if (rd1_b !== N'(i) || rd1_n !== N'(i)) begin
        n_fail++;
        $display("FAIL reset_rd1[%0d]: got %0d/%0d expected %0d", i, rd1_b, rd1_n, i);
      end
      n_tests++;
      if (rd2_b !== ((i + 1 == ZR) ? N'(0) : N'(i + 1)) || rd2_n !== rd2_b) begin
        n_fail++;
        $display("FAIL reset_rd2[%0d]: got %0d/%0d", i + 1, rd2_b, rd2_n);
      end
      n_tests++;
      if ({busy1_b, busy2_b, busy1_n, busy2_n} !== 4'b0 || pending_b !== '0 || pending_n !== '0) begin
        n_fail++;
        $display("FAIL reset_busy: busy=%b%b%b%b pending=%0d/%0d expected 0",
                 busy1_b, busy2_b, busy1_n, busy2_n, pending_b, pending_n);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_write_bypass();
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd2; wd3 = 64'd27; ra1 = 5'd2;
    #1;
    n_tests++;
    if (rd1_b !== 64'd27) begin
      n_fail++; $display("FAIL bypass_same_cycle: got %0d expected 27", rd1_b);
    end
    n_tests++;
    if (rd1_n !== 64'd2) begin
      n_fail++; $display("FAIL nobypass_pre_edge: got %0d expected 2", rd1_n);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (rd1_b !== 64'd27 || rd1_n !== 64'd27) begin
      n_fail++; $display("FAIL write_after_edge: got %0d/%0d expected 27", rd1_b, rd1_n);
    end
  endtask

  task automatic test_zero_reg();
    we3 = 1'b1; wa3 = 5'd31; wd3 = 64'd52; ra2 = 5'd31;
    #1;
    n_tests++;
    if (rd2_b !== '0 || rd2_n !== '0) begin
      n_fail++; $display("FAIL zero_bypass: got %0d/%0d expected 0", rd2_b, rd2_n);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (rd2_b !== '0 || rd2_n !== '0) begin
      n_fail++; $display("FAIL zero_write: got %0d/%0d expected 0", rd2_b, rd2_n);
    end
    iss_valid = 1'b1; iss_wa = 5'd31;
    tick();
    idle();
    #1;
    n_tests++;
    if (pending_b !== '0 || busy2_b !== 1'b0 || busy2_n !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_issue: pending=%0d busy2=%b/%b expected 0", pending_b, busy2_b, busy2_n);
    end
  endtask

  task automatic test_port_conflict();
    we3 = 1'b1; wa3 = 5'd7; wd3 = 64'd5;
    we4 = 1'b1; wa4 = 5'd7; wd4 = 64'd9; ra1 = 5'd7;
    #1;
    n_tests++;
    if (rd1_b !== 64'd9 || rd1_n !== 64'd7) begin
      n_fail++; $display("FAIL conflict_pre_edge: got %0d/%0d expected 9/7", rd1_b, rd1_n);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (rd1_b !== 64'd9 || rd1_n !== 64'd9) begin
      n_fail++; $display("FAIL conflict_post_edge: got %0d/%0d expected 9", rd1_b, rd1_n);
    end
  endtask

  task automatic test_scoreboard();
    iss_valid = 1'b1; iss_wa = 5'd4;
    tick();
    iss_wa = 5'd5;
    tick();
    idle();
    ra1 = 5'd4;
    #1;
    n_tests++;
    if (pending_b !== 6'd2 || pending_n !== 6'd2 || busy1_b !== 1'b1 || busy1_n !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_two_issued: pending=%0d busy1=%b/%b expected 2,1", pending_b, busy1_b, busy1_n);
    end
    we4 = 1'b1; wa4 = 5'd4; wd4 = 64'd44;
    #1;
    n_tests++;
    if (busy1_b !== 1'b0 || busy1_n !== 1'b1 || rd1_b !== 64'd44) begin
      n_fail++;
      $display("FAIL sb_clear_bypass: busy1=%b/%b rd1=%0d expected 0/1,44", busy1_b, busy1_n, rd1_b);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (pending_b !== 6'd1 || pending_n !== 6'd1 || busy1_b !== 1'b0 || busy1_n !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_after_clear: pending=%0d busy1=%b/%b expected 1,0", pending_b, busy1_b, busy1_n);
    end
    iss_valid = 1'b1; iss_wa = 5'd5; we4 = 1'b1; wa4 = 5'd5; wd4 = 64'd55; ra2 = 5'd5;
    tick();
    idle();
    #1;
    n_tests++;
    if (pending_b !== 6'd1 || busy2_b !== 1'b1 || busy2_n !== 1'b1 || rd2_b !== 64'd55) begin
      n_fail++;
      $display("FAIL sb_set_wins: pending=%0d busy2=%b/%b rd2=%0d expected 1,1,55",
               pending_b, busy2_b, busy2_n, rd2_b);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bit narrow = ($urandom_range(0, 1) == 1);
      int hi = narrow ? 7 : 31;
      ra1 = AW'($urandom_range(0, hi));
      ra2 = AW'($urandom_range(0, hi));
      wa3 = AW'($urandom_range(0, hi));
      wa4 = AW'($urandom_range(0, hi));
      iss_wa = AW'($urandom_range(0, hi));
      we3 = ($urandom_range(0, 1) == 1);
      we4 = ($urandom_range(0, 2) == 0);
      iss_valid = ($urandom_range(0, 2) == 0);
      wd3 = {$urandom, $urandom};
      wd4 = {$urandom, $urandom};
      #1;
      n_tests++;
      if (rd1_b !== exp_rd(ra1, 1) || rd2_b !== exp_rd(ra2, 1)) begin
        n_fail++;
        $display("FAIL rand_rd_bypass[%0d]: got %h/%h expected %h/%h", c, rd1_b, rd2_b,
                 exp_rd(ra1, 1), exp_rd(ra2, 1));
      end
      n_tests++;
      if (rd1_n !== exp_rd(ra1, 0) || rd2_n !== exp_rd(ra2, 0)) begin
        n_fail++;
        $display("FAIL rand_rd_nobypass[%0d]: got %h/%h expected %h/%h", c, rd1_n, rd2_n,
                 exp_rd(ra1, 0), exp_rd(ra2, 0));
      end
      n_tests++;
      if (busy1_b !== exp_busy(ra1, 1) || busy2_b !== exp_busy(ra2, 1) ||
          busy1_n !== exp_busy(ra1, 0) || busy2_n !== exp_busy(ra2, 0)) begin
        n_fail++;
        $display("FAIL rand_busy[%0d]: got %b%b/%b%b expected %b%b/%b%b", c, busy1_b, busy2_b,
                 busy1_n, busy2_n, exp_busy(ra1, 1), exp_busy(ra2, 1), exp_busy(ra1, 0),
                 exp_busy(ra2, 0));
      end
      n_tests++;
      if (int'(pending_b) != exp_pending() || int'(pending_n) != exp_pending()) begin
        n_fail++;
        $display("FAIL rand_pending[%0d]: got %0d/%0d expected %0d", c, pending_b, pending_n,
                 exp_pending());
      end
      tick();
    end
    idle();
  endtask

  task automatic test_async_reset();
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    iss_valid = 1'b1; iss_wa = 5'd1; we3 = 1'b1; wa3 = 5'd10; wd3 = 64'd99;
    tick();
    we3 = 1'b0; iss_wa = 5'd2;
    tick();
    iss_wa = 5'd3;
    tick();
    idle();
    ra1 = 5'd10; ra2 = 5'd1;
    #1;
    n_tests++;
    if (pending_b !== 6'd3 || rd1_b !== 64'd99 || busy2_b !== 1'b1) begin
      n_fail++;
      $display("FAIL async_setup: pending=%0d rd1=%0d busy2=%b expected 3,99,1",
               pending_b, rd1_b, busy2_b);
    end
    // Write in flight when reset hits; it must be lost.
    we3 = 1'b1; wa3 = 5'd12; wd3 = 64'd77;
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (pending_b !== '0 || pending_n !== '0 || rd1_b !== 64'd10 || rd1_n !== 64'd10 ||
        busy2_b !== 1'b0 || busy2_n !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: pending=%0d/%0d rd1=%0d/%0d busy2=%b/%b expected 0,10,0",
               pending_b, pending_n, rd1_b, rd1_n, busy2_b, busy2_n);
    end
    idle();
    reset_n = 1'b1;
    ra1 = 5'd12;
    tick();
    #1;
    n_tests++;
    if (rd1_b !== 64'd12 || rd1_n !== 64'd12 || pending_b !== '0) begin
      n_fail++;
      $display("FAIL async_lost_write: rd1=%0d/%0d pending=%0d expected 12,0",
               rd1_b, rd1_n, pending_b);
    end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_zero_reg();
    test_port_conflict();
    test_scoreboard();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
